// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes, FSM states
// and width-agnostic arithmetic helpers (operate on MDU_WMAX bits, callers size-cast).
package mips_mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MADD  = 4'b0100;
  localparam logic [3:0] OP_MADDU = 4'b0101;
  localparam logic [3:0] OP_MSUB  = 4'b0110;
  localparam logic [3:0] OP_MSUBU = 4'b0111;
  localparam logic [3:0] OP_MTHI  = 4'b1000;
  localparam logic [3:0] OP_MTLO  = 4'b1001;

  localparam int MDU_WMAX = 128;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} mdu_state_e;

  function automatic logic [MDU_WMAX-1:0] neg2w(input logic [MDU_WMAX-1:0] x);
    return ~x + 1'b1;
  endfunction

  // x must arrive sign-extended to MDU_WMAX so the top bit is the operand sign
  function automatic logic [MDU_WMAX-1:0] abs_val(input logic [MDU_WMAX-1:0] x,
                                                  input logic signed_op);
    return (signed_op && x[MDU_WMAX-1]) ? neg2w(x) : x;
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op[3:2] == 2'b01);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return op[3:1] == 3'b001;
  endfunction

endpackage

// File: rtl/mips_mdu_div_core.sv
// Restoring divider datapath on magnitudes: one quotient bit per enabled step.
module mips_mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);

  logic [XLEN-1:0] r_rem, r_quo, r_dvs;
  logic [XLEN:0]   w_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_df;

  // dividend bits shift out of the quotient register MSB as quotient bits enter the LSB
  assign w_sh = {r_rem, r_quo[XLEN-1]};
  assign w_ge = w_sh >= {1'b0, r_dvs};
  assign w_df = w_sh[XLEN-1:0] - r_dvs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_ge ? w_df : w_sh[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_ge};
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/mips_mdu_seq.sv
// Multi-cycle multiply/divide unit owning HI/LO; iterative shift-add multiplier
// (MUL_BPC bits per cycle), restoring divider, accumulate modes and kill.
module mips_mdu_seq
  import mips_mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  localparam int CW   = $clog2(XLEN) + 1;
  localparam int NMUL = XLEN / MUL_BPC;
  localparam int PW   = 2 * XLEN;

  generate
    if (!(MUL_BPC == 1 || MUL_BPC == 2 || MUL_BPC == 4) || (XLEN % MUL_BPC) != 0 ||
        PW > MDU_WMAX) begin : g_bad_param
      $error("mips_mdu_seq: illegal XLEN/MUL_BPC");
    end
  endgenerate

  mdu_state_e      r_state, w_nstate;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_mplier;
  logic [PW-1:0]   r_mcand, r_prod;
  logic            r_neg, r_qneg, r_rneg, r_acc, r_sub, r_isdiv, r_dz;
  logic            r_done, r_dbz;

  logic            w_accept, w_sgn, w_is_mul, w_is_div, w_bz;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_quo, w_rem, w_quo_s, w_rem_s;
  logic [PW-1:0]   w_pp, w_prod_s, w_acc, w_mulres;

  assign req_ready = (r_state == ST_IDLE) & ~kill;
  assign w_accept  = req_valid & req_ready;
  assign w_is_mul  = op_is_mul(req_op);
  assign w_is_div  = op_is_div(req_op);
  assign w_sgn     = ~req_op[0];
  assign w_bz      = (req_b == '0);
  assign w_abs_a   = XLEN'(abs_val(MDU_WMAX'($signed(req_a)), w_sgn));
  assign w_abs_b   = XLEN'(abs_val(MDU_WMAX'($signed(req_b)), w_sgn));

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (w_is_mul)      w_nstate = ST_MUL;
        else if (w_is_div) w_nstate = w_bz ? ST_FIX : ST_DIV;
      end
      ST_MUL:  if (r_cnt == CW'(NMUL - 1)) w_nstate = ST_FIX;
      ST_DIV:  if (r_cnt == CW'(XLEN - 1)) w_nstate = ST_FIX;
      ST_FIX:  w_nstate = ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
    if (kill) w_nstate = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  // MUL_BPC partial products of the shifted multiplicand, summed per cycle
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < MUL_BPC; j++)
      if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
  end

  assign w_prod_s = r_neg ? PW'(neg2w(MDU_WMAX'(r_prod))) : r_prod;
  assign w_acc    = {r_hi, r_lo};
  assign w_mulres = !r_acc ? w_prod_s : (r_sub ? w_acc - w_prod_s : w_acc + w_prod_s);
  assign w_quo_s  = r_qneg ? XLEN'(neg2w(MDU_WMAX'(w_quo))) : w_quo;
  assign w_rem_s  = r_rneg ? XLEN'(neg2w(MDU_WMAX'(w_rem))) : w_rem;

  mips_mdu_div_core #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept & w_is_div & ~w_bz),
    .i_step     ((r_state == ST_DIV) & ~kill),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0; r_hi <= '0; r_lo <= '0; r_mplier <= '0;
      r_mcand <= '0; r_prod <= '0;
      r_neg <= 1'b0; r_qneg <= 1'b0; r_rneg <= 1'b0;
      r_acc <= 1'b0; r_sub <= 1'b0; r_isdiv <= 1'b0; r_dz <= 1'b0;
      r_done <= 1'b0; r_dbz <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (!kill) begin
        case (r_state)
          ST_IDLE: if (req_valid) begin
            r_cnt   <= '0;
            r_acc   <= req_op[2];
            r_sub   <= req_op[2] & req_op[1];
            r_isdiv <= w_is_div;
            r_dz    <= w_is_div & w_bz;
            r_neg   <= w_sgn & (req_a[XLEN-1] ^ req_b[XLEN-1]);
            r_qneg  <= w_sgn & (req_a[XLEN-1] ^ req_b[XLEN-1]);
            r_rneg  <= w_sgn & req_a[XLEN-1];
            if (w_is_mul) begin
              r_mcand  <= PW'(w_abs_a);
              r_mplier <= w_abs_b;
              r_prod   <= '0;
            end else if (!w_is_div) begin
              if (req_op == OP_MTHI) r_hi <= req_a;
              if (req_op == OP_MTLO) r_lo <= req_a;
              r_done <= 1'b1;
            end
          end
          ST_MUL: begin
            r_prod   <= r_prod + w_pp;
            r_mcand  <= r_mcand << MUL_BPC;
            r_mplier <= r_mplier >> MUL_BPC;
            r_cnt    <= r_cnt + 1'b1;
          end
          ST_DIV: r_cnt <= r_cnt + 1'b1;
          ST_FIX: begin
            r_done <= 1'b1;
            if (r_dz) r_dbz <= 1'b1;
            else if (r_isdiv) begin
              r_hi <= w_rem_s;
              r_lo <= w_quo_s;
            end else begin
              {r_hi, r_lo} <= w_mulres;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;

endmodule

// File: tb/tb_mips_mdu_seq.sv
// Directed bench for mips_mdu_seq: default build plus a MUL_BPC=4 build.
module tb_mips_mdu_seq;
  import mips_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, v4 = 1'b0, kill = 1'b0;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        rdy, busy, done, dbz, rdy4, busy4, done4, dbz4;
  logic [31:0] hi, lo, hi4, lo4;

  int checks = 0, failures = 0;
  int lat, bc, seen;

  always #5 clk = ~clk;

  mips_mdu_seq #(.XLEN(32), .MUL_BPC(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .kill(kill), .busy(busy), .done(done),
    .div_by_zero(dbz), .hi_out(hi), .lo_out(lo));

  mips_mdu_seq #(.XLEN(32), .MUL_BPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(rdy4), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .kill(kill), .busy(busy4), .done(done4),
    .div_by_zero(dbz4), .hi_out(hi4), .lo_out(lo4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge where done is seen
  task automatic do_op(input bit sel, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int l, output int bcy);
    req_op = op; req_a = a; req_b = b;
    #1 chk("ready_before_issue", sel ? rdy4 : rdy, 1);
    if (sel) v4 = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; v4 = 1'b0;
    l = 0; bcy = 0;
    while (!(sel ? done4 : done) && l < 100) begin
      if (sel ? busy4 : busy) bcy++;
      @(negedge clk);
      l++;
    end
    chk("done_within_bound", (l < 100), 1);
  endtask

  initial begin
    #3;
    chk("rst_hi", hi, 0);  chk("rst_lo", lo, 0);
    chk("rst_done", done, 0); chk("rst_dbz", dbz, 0); chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", rdy, 1);
    @(negedge clk);

    // signed multiply
    do_op(0, OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bc);
    chk("mult_lat", lat, 33); chk("mult_busy_cycles", bc, 33);
    chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFEB);

    // back-to-back issue in the done cycle, then accumulate
    do_op(0, OP_MTHI, 32'h0, 32'h0, lat, bc);
    chk("mthi_lat", lat, 0); chk("mthi_hi", hi, 0);
    do_op(0, OP_MTLO, 32'd10, 32'h0, lat, bc);
    chk("mtlo_lo", lo, 32'd10);
    do_op(0, OP_MADDU, 32'hFFFFFFFF, 32'd2, lat, bc);
    chk("maddu_hi", hi, 32'h2); chk("maddu_lo", lo, 32'h8);
    do_op(0, OP_MSUB, 32'd1, 32'd1, lat, bc);
    chk("msub_hi", hi, 32'h2); chk("msub_lo", lo, 32'h7);

    // division
    do_op(0, OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bc);
    chk("div_lat", lat, 33);
    chk("div_hi", hi, 32'hFFFFFFFF); chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_dbz", dbz, 0);
    do_op(0, OP_DIVU, 32'h80000000, 32'd3, lat, bc);
    chk("divu_lo", lo, 32'h2AAAAAAA); chk("divu_hi", hi, 32'h2);

    // divide by zero
    do_op(0, OP_DIV, 32'd5, 32'd0, lat, bc);
    chk("dz_lat", lat, 1); chk("dz_flag", dbz, 1);
    chk("dz_hi", hi, 32'h2); chk("dz_lo", lo, 32'h2AAAAAAA);
    @(negedge clk);
    chk("dz_done_pulse", done, 0); chk("dz_flag_pulse", dbz, 0);

    do_op(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    chk("minneg1_lo", lo, 32'h80000000); chk("minneg1_hi", hi, 0);
    chk("minneg1_dbz", dbz, 0);

    // illegal op: done pulse, no change
    do_op(0, 4'b1100, 32'h55, 32'h66, lat, bc);
    chk("illegal_lat", lat, 0); chk("illegal_hi", hi, 0);
    chk("illegal_lo", lo, 32'h80000000);

    do_op(0, OP_MTHI, 32'h1234, 32'h0, lat, bc);
    do_op(0, OP_MTLO, 32'h5678, 32'h0, lat, bc);

    // kill mid-multiply at iteration 10
    req_op = OP_MULTU; req_a = 32'h12345; req_b = 32'h777; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1 chk("kill_busy", busy, 0); chk("kill_ready", rdy, 1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    chk("kill_no_done", seen, 0);
    chk("kill_hi", hi, 32'h1234); chk("kill_lo", lo, 32'h5678);

    // kill in the FIX cycle suppresses the write
    req_op = OP_MULT; req_a = 32'd3; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (32) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("killfix_done", done, 0); chk("killfix_lo", lo, 32'h5678);

    // kill with req_valid in IDLE: not accepted
    kill = 1'b1; req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'hDEAD;
    #1 chk("kill_idle_ready", rdy, 0);
    @(posedge clk); @(negedge clk);
    kill = 1'b0; req_valid = 1'b0;
    chk("kill_idle_done", done, 0);
    @(negedge clk);
    chk("kill_idle_hi", hi, 32'h1234); chk("kill_idle_busy", busy, 0);

    // 4 bits per cycle build
    do_op(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    chk("bpc4_lat", lat, 9);
    chk("bpc4_hi", hi4, 32'hFFFFFFFE); chk("bpc4_lo", lo4, 32'h00000001);
    chk("bpc4_dbz", dbz4, 0);

    // asynchronous reset mid-divide
    req_op = OP_DIVU; req_a = 32'd1000; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_hi", hi, 0); chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk("arst_hi4", hi4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_ready", rdy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
